regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file with write-through bypass and a
//  per-register busy scoreboard. It replaces the single-write, two-read file in the
//  decode stage of the pipelined core. The issue logic marks destination registers
//  busy, writeback clears them, and the read ports report data plus busy for hazard
//  detection.
// PARAMETERS
//  XLEN      32  data width in bits
//  NREGS     32  number of architectural registers (power of 2, >=2)
//  NUM_RD    2   number of read ports
//  NUM_WR    2   number of write ports; higher index has priority
//  BYPASS    1   1: same-cycle write data is forwarded to reads; 0: reads return stored value
//  ZERO_REG  1   1: register 0 reads 0, ignores writes and is never busy
// PORTS
//  clk        in   1                 rising-edge clock
//  reset_n    in   1                 asynchronous, active-low reset
//  rd_addr    in   NUM_RD*AW         read addresses, AW = $clog2(NREGS)
//  rd_data    out  NUM_RD*XLEN       read data (combinational)
//  rd_busy    out  NUM_RD            scoreboard busy bit of each addressed register
//  wr_en      in   NUM_WR            write-port enables
//  wr_addr    in   NUM_WR*AW         write addresses
//  wr_data    in   NUM_WR*XLEN       write data
//  iss_en     in   1                 issue: mark iss_rd busy
//  iss_rd     in   AW                destination register being issued
//  flush      in   1                 clear all busy bits (pipeline squash)
//  busy_vec   out  NREGS             full scoreboard, for debug and stall logic
// BEHAVIOUR
//  Reset (reset_n=0, async): all registers = 0 and all busy = 0, immediately. This
//   holds mid-operation too; writes, issues and flushes in that cycle are discarded.
//  Write: on posedge, for each register the highest-index port with wr_en and
//   matching wr_addr writes it. Lower ports to the same address are dropped.
//  Read: rd_data is combinational. With BYPASS=1, a same-cycle write to rd_addr
//   (after priority resolution) returns wr_data; otherwise it returns the stored value.
//   Read latency is 0 cycles and write-to-read is 1 cycle (0 with BYPASS).
//  Zero reg (ZERO_REG=1): reads of address 0 return 0 (bypass included), writes to
//   address 0 are ignored, and busy[0] stays 0 (iss_rd=0 has no effect).
//  Scoreboard: next busy[r] is evaluated in priority order (highest first):
//   1. flush: 0 (flush also wins over iss_en in the same cycle).
//   2. iss_en && iss_rd==r: 1 (a new producer beats a same-cycle writeback to r).
//   3. any wr_en to r: 0.
//   4. otherwise: unchanged.
//  rd_busy/busy_vec report the registered busy state, not the next state.
//  Writes still update data when flush=1; flush affects busy only.
//  Address arithmetic is unsigned AW bits. Out-of-range addresses are impossible
//   because NREGS is a power of 2.
// STRUCTURE
//  Package regfile_pkg: reg_addr_t (logic [AW-1:0]), xlen_t, and function
//   wr_winner() that returns the winning write port index per register.
//  Sub-module regfile_cell: one XLEN-bit register with async active-low reset and
//   enable. Generate NREGS instances (index 0 is omitted when ZERO_REG=1).
//  Write decode, bypass mux and scoreboard are in the top module.
// TESTING
//  1. Reset: drive reset_n low mid-run after writing x5=0xDEAD -> rd_data=0 and
//     busy_vec=0 asynchronously, before the next clock edge.
//  2. Write then read: wr_en[0], x3=0x1234 -> the next cycle rd_addr=3 gives 0x1234.
//     With BYPASS=1 the same cycle also gives 0x1234; with BYPASS=0 it gives the old value.
//  3. Port priority: wr0 x7=0xAAAA and wr1 x7=0x5555 in the same cycle -> x7=0x5555.
//     The bypassed read also gives 0x5555.
//  4. Zero reg: write x0=0xFFFF_FFFF and iss_rd=0 -> x0 reads 0 and busy[0]=0.
//  5. Scoreboard: issue x9 -> busy[9]=1. Writeback x9 -> busy[9]=0.
//     Issue x9 and write x9 in the same cycle -> busy[9]=1 and data updated.
//  6. Flush: busy x4 and x12, then flush together with iss_en x4 -> busy_vec=0.
//     A write in the flush cycle still lands.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and the write-port arbitration helper for the multi-port register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  // Arbitration runs on inputs padded to these ceilings, so NUM_WR and AW must not exceed them
  localparam int MAX_WR   = 8;
  localparam int MAX_AW   = 16;
  localparam int WR_IDX_W = $clog2(MAX_WR);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xlen_t;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] port;
  } wr_sel_t;

  function automatic wr_sel_t wr_winner(
    input logic [MAX_WR-1:0]        en,
    input logic [MAX_WR*MAX_AW-1:0] addr,
    input int unsigned              r
  );
    wr_sel_t sel;
    sel.hit  = 1'b0;
    sel.port = '0;
    // Later ports overwrite earlier matches, so the highest index wins
    for (int p = 0; p < MAX_WR; p++) begin
      if (en[p] && (addr[p*MAX_AW +: MAX_AW] == r[MAX_AW-1:0])) begin
        sel.hit  = 1'b1;
        sel.port = WR_IDX_W'(p);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// Single register of the file: async active-low reset, load on enable.
module regfile_cell #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with prioritised writes, write-through bypass and a
// per-register busy scoreboard for hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_rd,
  input  logic                   flush,
  output logic [NREGS-1:0]       busy_vec
);

  logic [MAX_WR-1:0]        en_pad;
  logic [MAX_WR*MAX_AW-1:0] addr_pad;
  logic                     win_hit  [NREGS];
  logic [XLEN-1:0]          win_data [NREGS];
  logic [XLEN-1:0]          regs     [NREGS];
  logic [NREGS-1:0]         busy_q;
  logic [NREGS-1:0]         busy_d;

  always_comb begin
    en_pad   = '0;
    addr_pad = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      en_pad[p]                    = wr_en[p];
      addr_pad[p*MAX_AW +: MAX_AW] = MAX_AW'(wr_addr[p*AW +: AW]);
    end
  end

  // Resolve one winning write per register; register 0 never accepts a write when hardwired
  always_comb begin
    wr_sel_t sel;
    for (int r = 0; r < NREGS; r++) begin
      sel         = wr_winner(en_pad, addr_pad, r);
      win_hit[r]  = sel.hit && !((ZERO_REG != 0) && (r == 0));
      win_data[r] = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (int'(sel.port) == p)
          win_data[r] = wr_data[p*XLEN +: XLEN];
      end
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if ((ZERO_REG != 0) && (r == 0)) begin : g_zero
      assign regs[r] = '0;
    end else begin : g_cell
      regfile_cell #(.W(XLEN)) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (win_hit[r]),
        .d       (win_data[r]),
        .q       (regs[r])
      );
    end
  end

  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = rd_addr[i*AW +: AW];
      d = regs[a];
      if ((BYPASS != 0) && win_hit[a])
        d = win_data[a];
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i]              = busy_q[a];
    end
  end

  // Priority low to high: writeback clears, issue sets, flush clears everything
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (win_hit[r])
        busy_d[r] = 1'b0;
      if (iss_en && (iss_rd == r[AW-1:0]))
        busy_d[r] = 1'b1;
      if (flush)
        busy_d[r] = 1'b0;
      if ((ZERO_REG != 0) && (r == 0))
        busy_d[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule
